// File: rtl/vga_spi_master.sv
// Mode-0 SPI initiator for the vga_clock register port.
// Byte-stream valid/ready TX side, pulse-qualified RX side, burst chip select.
module vga_spi_master #(
    parameter int DIV    = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              abort,
    output logic              busy,
    output logic              SPI_clk,
    output logic              SPI_csb,
    output logic              SPI_copi,
    input  logic              SPI_cipo
);

    localparam int CW = $clog2(DIV + 1);
    localparam int EW = $clog2(2 * DATA_W) + 1;

    localparam logic [CW-1:0] RELOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(DIV);
    localparam logic [EW-1:0] LAST_E  = EW'(2 * DATA_W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] NEXT  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [EW-1:0]     edge_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              last_q;
    logic              accept;

    assign accept = tx_valid && tx_ready;

    // Transfer sequencer: all SPI pins and user-side flags are registered here.
    // HOLD is loaded with DIV (not DIV-1) because the final falling-edge
    // cycle itself is spent in HOLD before the DIV cycles of select hold.
    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            last_q   <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            SPI_clk  <= 1'b0;
            SPI_csb  <= 1'b1;
            SPI_copi <= 1'b0;
        end else if (state != IDLE && abort) begin
            state    <= GAP;
            cnt      <= RELOAD;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            SPI_clk  <= 1'b0;
            SPI_csb  <= 1'b1;
            SPI_copi <= 1'b0;
        end else begin
            case (state)
                IDLE, NEXT: begin
                    tx_ready <= 1'b1;
                    SPI_clk  <= 1'b0;
                    SPI_csb  <= (state == IDLE);
                    busy     <= (state != IDLE);
                    if (accept) begin
                        tx_sr    <= tx_data;
                        last_q   <= tx_last;
                        SPI_copi <= tx_data[DATA_W-1];
                        SPI_csb  <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= RELOAD;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        SPI_clk  <= 1'b1;
                        rx_sr    <= {rx_sr[DATA_W-2:0], SPI_cipo};
                        edge_cnt <= EW'(1);
                        cnt      <= RELOAD;
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        cnt      <= RELOAD;
                        SPI_clk  <= ~SPI_clk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (!SPI_clk) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], SPI_cipo};
                        end else if (edge_cnt == LAST_E) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_sr;
                            if (last_q) begin
                                cnt   <= HOLD_LD;
                                state <= HOLD;
                            end else begin
                                tx_ready <= 1'b1;
                                state    <= NEXT;
                            end
                        end else begin
                            SPI_copi <= tx_sr[DATA_W-2];
                            tx_sr    <= tx_sr << 1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        SPI_csb <= 1'b1;
                        cnt     <= RELOAD;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_spi_master.sv
// Directed bench for vga_spi_master: DIV=2 loopback instance plus
// a DIV=1 instance with SPI_cipo tied high.
module tb_vga_spi_master;

    logic       clk;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       abort;
    logic       busy;
    logic       sclk;
    logic       csb;
    logic       copi;

    logic       tx_valid1;
    logic [7:0] tx_data1;
    logic       tx_last1;
    logic       tx_ready1;
    logic       rx_valid1;
    logic [7:0] rx_data1;
    logic       busy1;
    logic       sclk1;
    logic       csb1;
    logic       copi1;

    int errors;
    int checks;

    vga_spi_master #(.DIV(2), .DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .abort    (abort),
        .busy     (busy),
        .SPI_clk  (sclk),
        .SPI_csb  (csb),
        .SPI_copi (copi),
        .SPI_cipo (copi)
    );

    vga_spi_master #(.DIV(1), .DATA_W(8)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid1),
        .tx_data  (tx_data1),
        .tx_last  (tx_last1),
        .tx_ready (tx_ready1),
        .rx_valid (rx_valid1),
        .rx_data  (rx_data1),
        .abort    (1'b0),
        .busy     (busy1),
        .SPI_clk  (sclk1),
        .SPI_csb  (csb1),
        .SPI_copi (copi1),
        .SPI_cipo (1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait for tx_ready, present one word, return at sample point of T+1.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait: tx_ready=%b required 1", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        while (!tx_ready1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (tx_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL send1_wait: tx_ready=%b required 1", tx_ready1);
        end
        tx_valid1 = 1'b1;
        tx_data1  = d;
        tx_last1  = l;
        @(posedge clk); #1;
        tx_valid1 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({csb, sclk, copi, tx_ready, rx_valid, busy} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: csb,clk,copi,rdy,rxv,busy=%b required 100000",
                     {csb, sclk, copi, tx_ready, rx_valid, busy});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rxdata: got %h required 00", rx_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        int first_low, last_low, rises, rxv_n, rxv_k, busy1_k;
        logic prev;
        logic [7:0] got;
        logic rdy37, rdy38;
        first_low = -1; last_low = -1; rises = 0; rxv_n = 0; rxv_k = -1;
        busy1_k = 0; prev = 1'b0; got = 8'h00; rdy37 = 1'bx; rdy38 = 1'bx;
        send(8'hA5, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            if (csb === 1'b0) begin
                if (first_low < 0) first_low = k;
                last_low = k;
            end
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
            if (rx_valid === 1'b1) begin
                rxv_n++;
                rxv_k = k;
                got = rx_data;
            end
            if (k == 1) busy1_k = busy;
            if (k == 37) rdy37 = tx_ready;
            if (k == 38) rdy38 = tx_ready;
            @(posedge clk); #1;
        end
        checks++;
        if (first_low != 1 || last_low != 35) begin
            errors++;
            $display("FAIL single_csb: low %0d..%0d required 1..35", first_low, last_low);
        end
        checks++;
        if (rises != 8) begin
            errors++;
            $display("FAIL single_rises: got %0d required 8", rises);
        end
        checks++;
        if (rxv_n != 1 || rxv_k != 33) begin
            errors++;
            $display("FAIL single_rxv: %0d pulses at %0d required 1 at 33", rxv_n, rxv_k);
        end
        checks++;
        if (got !== 8'hA5) begin
            errors++;
            $display("FAIL single_rxdata: got %h required a5", got);
        end
        checks++;
        if (busy1_k !== 1 || rdy37 !== 1'b0 || rdy38 !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: busy=%0d rdy37=%b rdy38=%b required 1 0 1",
                     busy1_k, rdy37, rdy38);
        end
    endtask

    task automatic test_back_to_back;
        int csb_hi, rxn;
        int rk[2];
        logic [7:0] rd[2];
        logic sent, csb69;
        csb_hi = 0; rxn = 0; sent = 1'b0; csb69 = 1'bx;
        rk[0] = -1; rk[1] = -1; rd[0] = 8'h00; rd[1] = 8'h00;
        send(8'h12, 1'b0);
        for (int k = 1; k <= 80; k++) begin
            if (tx_valid) tx_valid = 1'b0;
            if (k <= 68 && csb !== 1'b0) csb_hi++;
            if (k == 69) csb69 = csb;
            if (rx_valid === 1'b1) begin
                if (rxn < 2) begin
                    rk[rxn] = k;
                    rd[rxn] = rx_data;
                end
                rxn++;
            end
            if (!sent && tx_ready === 1'b1) begin
                tx_valid = 1'b1;
                tx_data  = 8'h34;
                tx_last  = 1'b1;
                sent     = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (csb_hi != 0 || csb69 !== 1'b1) begin
            errors++;
            $display("FAIL burst_csb: high_cycles=%0d csb69=%b required 0 1", csb_hi, csb69);
        end
        checks++;
        if (rxn != 2 || rk[0] != 33 || rk[1] != 66) begin
            errors++;
            $display("FAIL burst_rxv: n=%0d at %0d,%0d required 2 at 33,66", rxn, rk[0], rk[1]);
        end
        checks++;
        if (rd[0] !== 8'h12 || rd[1] !== 8'h34) begin
            errors++;
            $display("FAIL burst_data: got %h %h required 12 34", rd[0], rd[1]);
        end
    endtask

    task automatic test_stall;
        int bad, n, rk, csb_k36;
        logic [7:0] got;
        bad = 0; n = 0; rk = -1; got = 8'h00; csb_k36 = -1;
        send(8'h3C, 1'b0);
        while (tx_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (rx_valid === 1'b1) got = rx_data;
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("FAIL stall_first: rx=%h required 3c", got);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 50; k++) begin
            if (csb !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0)
                bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d bad cycles required 0", bad);
        end
        got = 8'h00;
        send(8'hC3, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            if (rx_valid === 1'b1) begin
                rk = k;
                got = rx_data;
            end
            if (k == 36) csb_k36 = csb;
            @(posedge clk); #1;
        end
        checks++;
        if (rk != 33 || got !== 8'hC3 || csb_k36 != 1) begin
            errors++;
            $display("FAIL stall_resume: rx %h at %0d csb36=%0d required c3 at 33 csb 1",
                     got, rk, csb_k36);
        end
    endtask

    task automatic test_abort;
        int rises, ak, rxn;
        logic prev;
        logic [3:0] after1;
        logic r1, r2, r3, b3;
        rises = 0; ak = -1; rxn = 0; prev = 1'b0;
        after1 = 4'hx; r1 = 1'bx; r2 = 1'bx; r3 = 1'bx; b3 = 1'bx;
        send(8'h96, 1'b1);
        for (int k = 1; k <= 40 && ak < 0; k++) begin
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
            if (rx_valid === 1'b1) rxn++;
            if (rises == 3) begin
                ak = k;
                abort = 1'b1;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        after1 = {csb, sclk, copi, busy};
        r1 = tx_ready;
        @(posedge clk); #1;
        r2 = tx_ready;
        @(posedge clk); #1;
        r3 = tx_ready;
        b3 = busy;
        for (int k = 0; k < 30; k++) begin
            if (rx_valid === 1'b1) rxn++;
            @(posedge clk); #1;
        end
        checks++;
        if (ak != 11) begin
            errors++;
            $display("FAIL abort_third_rise: at %0d required 11", ak);
        end
        checks++;
        if (after1 !== 4'b1001) begin
            errors++;
            $display("FAIL abort_pins: csb,clk,copi,busy=%b required 1001", after1);
        end
        checks++;
        if ({r1, r2, r3, b3} !== 4'b0010) begin
            errors++;
            $display("FAIL abort_ready: rdy1,rdy2,rdy3,busy3=%b required 0010",
                     {r1, r2, r3, b3});
        end
        checks++;
        if (rxn != 0) begin
            errors++;
            $display("FAIL abort_norx: %0d pulses required 0", rxn);
        end
    endtask

    task automatic test_reset_mid;
        int rk;
        logic [7:0] got;
        rk = -1; got = 8'h00;
        send(8'h77, 1'b1);
        repeat (12) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({csb, sclk, copi, tx_ready, rx_valid, busy} !== 6'b100000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: pins=%b rx=%h required 100000 00",
                     {csb, sclk, copi, tx_ready, rx_valid, busy}, rx_data);
        end
        send(8'h5A, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            if (rx_valid === 1'b1) begin
                rk = k;
                got = rx_data;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rk != 33 || got !== 8'h5A) begin
            errors++;
            $display("FAIL reset_resume: rx %h at %0d required 5a at 33", got, rk);
        end
    endtask

    task automatic test_div1;
        int first_r, last_r, prev_r, bad_gap, copi_hi, rk;
        logic prev;
        logic [7:0] got;
        first_r = -1; last_r = -1; prev_r = -1; bad_gap = 0; copi_hi = 0;
        rk = -1; prev = 1'b0; got = 8'h00;
        send1(8'h00, 1'b1);
        for (int k = 1; k <= 25; k++) begin
            if (sclk1 === 1'b1 && prev === 1'b0) begin
                if (first_r < 0) first_r = k;
                if (prev_r >= 0 && k - prev_r != 2) bad_gap++;
                prev_r = k;
                last_r = k;
            end
            prev = sclk1;
            if (copi1 !== 1'b0) copi_hi++;
            if (rx_valid1 === 1'b1) begin
                rk = k;
                got = rx_data1;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (first_r != 2 || last_r != 16 || bad_gap != 0) begin
            errors++;
            $display("FAIL div1_clk: rises %0d..%0d bad_gap=%0d required 2..16 0",
                     first_r, last_r, bad_gap);
        end
        checks++;
        if (copi_hi != 0) begin
            errors++;
            $display("FAIL div1_copi: %0d high cycles required 0", copi_hi);
        end
        checks++;
        if (rk != 17 || got !== 8'hFF) begin
            errors++;
            $display("FAIL div1_rx: rx %h at %0d required ff at 17", got, rk);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        abort     = 1'b0;
        tx_valid1 = 1'b0;
        tx_data1  = 8'h00;
        tx_last1  = 1'b0;
        #1;
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_abort;
        test_reset_mid;
        test_div1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
